square_rr_sched: RTL and testbench

//   Round-robin scheduler sharing one multi-cycle squaring unit among NREQ requesters.

---
 rtl/square_rr_sched.sv | 124 ++++++++++++
 tb/tb_square_rr_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/square_rr_sched.sv
// Round-robin scheduler that shares one shift-add squaring unit among NREQ requesters.
// The winning operand is squared one bit per cycle, and the result is returned with the requester id.
module square_rr_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   operand,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    res_valid,
    output logic [2*WIDTH-1:0]      res_data,
    output logic [IDW-1:0]          res_id,
    input  logic                    res_ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state, state_nxt;
    logic [IDW-1:0]         ptr;
    logic [IDW-1:0]         pick;
    logic                   pick_vld;
    int                     idx;
    logic [WIDTH-1:0]       op_p0;
    logic [RW-1:0]          acc_p0;
    logic [RW-1:0]          acc_sum;
    logic [CW-1:0]          cnt;
    logic [IDW-1:0]         id_p0;
    logic                   last_bit;

    // Shift-add partial term for one multiplier bit of op*op.
    function automatic logic [RW-1:0] partial_term(input logic [WIDTH-1:0] op,
                                                   input logic [CW-1:0]    sh);
        logic [RW-1:0] ext;
        ext = {{WIDTH{1'b0}}, op};
        if (op[sh]) return ext << sh;
        return '0;
    endfunction

    // Search starts one past the last grant so a just-served requester ranks last.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick     = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last_bit  = (cnt == CW'(WIDTH - 1));
        acc_sum   = acc_p0 + partial_term(op_p0, cnt);
        case (state)
            IDLE:    if (pick_vld)  state_nxt = CALC;
            CALC:    if (last_bit)  state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture stage (IDLE grant) feeds the bit-serial accumulate stage (CALC) and the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            ptr       <= IDW'(NREQ - 1);
            op_p0     <= '0;
            acc_p0    <= '0;
            cnt       <= '0;
            id_p0     <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt    <= NREQ'(1) << pick;
                        op_p0  <= operand[pick*WIDTH +: WIDTH];
                        id_p0  <= pick;
                        acc_p0 <= '0;
                        cnt    <= '0;
                        ptr    <= pick;
                        busy   <= 1'b1;
                    end
                end
                CALC: begin
                    acc_p0 <= acc_sum;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        res_data  <= acc_sum;
                        res_id    <= id_p0;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_square_rr_sched.sv
// Scoreboard bench for square_rr_sched: a transaction-level model predicts grants and results,
// and a separate monitor compares them against what the DUT presents.
module tb_square_rr_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 2;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] operand;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  res_valid;
    logic [2*WIDTH-1:0]    res_data;
    logic [IDW-1:0]        res_id;
    logic                  res_ready;

    square_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .operand(operand), .gnt(gnt),
        .busy(busy), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready)
    );

    typedef struct { int id; int cyc; } gexp_t;
    typedef struct { int id; int data; int vcyc; } rexp_t;

    gexp_t exp_g[$];
    rexp_t exp_r[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_gnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Reference model: one job at a time, round-robin pick, result after WIDTH cycles,
    // held until accepted, free again on the edge after acceptance.
    initial begin : model
        int ptr, wait_left, pick, opv;
        bit m_busy;
        ptr = NREQ - 1; wait_left = 0; m_busy = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                ptr = NREQ - 1; wait_left = 0; m_busy = 0;
                exp_g.delete();
                exp_r.delete();
            end else if (!m_busy) begin
                if (req != 0) begin
                    pick = -1;
                    for (int k = 1; k <= NREQ; k++)
                        if (pick < 0 && req[(ptr + k) % NREQ]) pick = (ptr + k) % NREQ;
                    opv = int'(operand[pick*WIDTH +: WIDTH]);
                    exp_g.push_back('{id: pick, cyc: cyc});
                    exp_r.push_back('{id: pick, data: opv * opv, vcyc: cyc + WIDTH});
                    ptr = pick; m_busy = 1; wait_left = WIDTH;
                end
            end else if (wait_left > 0) begin
                wait_left--;
            end else if (res_ready) begin
                m_busy = 0;
            end
        end
    end

    // Monitor: samples after inputs settle for the coming edge.
    initial begin : monitor
        bit pv, pr;
        logic [2*WIDTH-1:0] pd;
        logic [IDW-1:0] pid;
        gexp_t g;
        rexp_t r;
        pv = 0; pr = 0; pd = '0; pid = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk("reset_outputs", {gnt, busy, res_valid, res_data, res_id}, 0);
                pv = 0; pr = 0;
                continue;
            end
            if (gnt != 0) begin
                n_gnt++;
                if (exp_g.size() == 0) chk("gnt_unexpected", gnt, 0);
                else begin
                    g = exp_g.pop_front();
                    chk("gnt_id", gnt, 1 << g.id);
                    chk("gnt_cycle", cyc, g.cyc);
                end
            end else if (exp_g.size() > 0 && exp_g[0].cyc <= cyc) begin
                g = exp_g.pop_front();
                chk("gnt_missing", gnt, 1 << g.id);
            end
            if (res_valid && !pv) begin
                if (exp_r.size() == 0) chk("res_unexpected", res_valid, 0);
                else begin
                    chk("res_data", res_data, exp_r[0].data);
                    chk("res_id", res_id, exp_r[0].id);
                    chk("res_latency", cyc, exp_r[0].vcyc);
                end
            end else if (!res_valid && !pv && exp_r.size() > 0 && cyc >= exp_r[0].vcyc) begin
                r = exp_r.pop_front();
                chk("res_missing", res_valid, 1);
            end
            if (pv && !pr) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_data_id", {res_data, res_id}, {pd, pid});
            end
            if (pv && pr) begin
                chk("accept_clears_valid", res_valid, 0);
                chk("data_kept_after_accept", res_data, pd);
            end
            if (res_valid) chk("busy_with_result", busy, 1);
            if (res_valid && res_ready && exp_r.size() > 0) r = exp_r.pop_front();
            pv = res_valid; pr = res_ready; pd = res_data; pid = res_id;
        end
    end

    task automatic wait_gnt(input string nm, input int limit);
        bit found;
        found = 0;
        for (int t = 0; t < limit && !found; t++) begin
            tick;
            if (gnt != 0) found = 1;
        end
        if (!found) chk({nm, "_timeout"}, gnt, 1);
    endtask

    task automatic rand_step;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && ($urandom % 2 == 0)) req[i] = 1'b0;
            else if (!req[i] && ($urandom % 4 == 0)) begin
                req[i] = 1'b1;
                operand[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
        end
        res_ready = ($urandom % 3) != 0;
    endtask

    initial begin : stim
        bit found;
        rst_n = 1'b0; req = NREQ'($urandom); operand = (NREQ*WIDTH)'($urandom); res_ready = 1'b0;
        repeat (3) tick;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_id", res_id, 0);
        rst_n = 1'b1; req = '0;
        tick;

        // Single request, top operand value
        req = 4'b0100; operand = (NREQ*WIDTH)'($urandom); operand[2*WIDTH +: WIDTH] = WIDTH'(3);
        res_ready = 1'b1;
        wait_gnt("t2_gnt", 10);
        chk("t2_gnt_val", gnt, 4'b0100);
        req = '0;
        tick;
        chk("t2_gnt_pulse", gnt, 0);
        tick;
        chk("t2_valid", res_valid, 1);
        chk("t2_data", res_data, 9);
        chk("t2_id", res_id, 2);
        repeat (3) tick;

        // All requesters held: cyclic grants
        for (int i = 0; i < NREQ; i++) operand[i*WIDTH +: WIDTH] = WIDTH'(i);
        req = '1;
        repeat (70) tick;
        req = '0;
        repeat (8) tick;

        // Backpressure hold
        res_ready = 1'b0;
        operand[0 +: WIDTH] = WIDTH'(2);
        req = 4'b0001;
        wait_gnt("t4_gnt", 10);
        req = 4'b0010;
        found = 0;
        for (int t = 0; t < 10 && !found; t++) begin
            tick;
            if (res_valid) found = 1;
        end
        chk("t4_valid_rise", res_valid, 1);
        for (int t = 0; t < 5; t++) begin
            tick;
            chk("t4_no_gnt", gnt, 0);
            chk("t4_held_valid", res_valid, 1);
            chk("t4_held_data", res_data, 4);
        end
        res_ready = 1'b1;
        tick;
        chk("t4_accepted", res_valid, 0);
        tick;
        chk("t4_next_gnt", gnt, 4'b0010);
        req = '0;
        repeat (8) tick;

        // Reset in the middle of a job
        req = 4'b0100;
        wait_gnt("t5_gnt", 10);
        req = '0; rst_n = 1'b0;
        tick;
        chk("t5_rst_valid", res_valid, 0);
        rst_n = 1'b1; req = 4'b1001;
        tick;
        chk("t5_first_gnt", gnt, 4'b0001);
        req = 4'b1000;
        repeat (12) tick;
        req = '0;
        repeat (6) tick;

        // Random traffic with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 400 == 0) begin
                rst_n = 1'b0;
                tick;
                rst_n = 1'b1;
            end
            rand_step;
            tick;
        end

        req = '0; res_ready = 1'b1;
        repeat (20) tick;
        chk("drain_gnt_queue", exp_g.size(), 0);
        chk("drain_res_queue", exp_r.size(), 0);
        chk("grants_seen", n_gnt > 20, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
